// File: rtl/env_follower.sv
// Envelope follower with slew-limited attack/release, hysteretic gate with hold, and peak capture.
// All state advances on sample-rate updates (ce qualified by sample_valid).
module env_follower (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_sample_valid,
    input  logic [7:0] i_sample,
    input  logic [7:0] i_ai,
    input  logic [7:0] i_ri,
    input  logic [7:0] i_th_on,
    input  logic [7:0] i_th_off,
    input  logic [7:0] i_hold,
    input  logic       i_peak_clr,
    output logic [7:0] o_envelope,
    output logic       o_gate,
    output logic [7:0] o_peak
);

    typedef enum logic [1:0] {StIdle, StOn, StHold} state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_d;
    logic [7:0] r_env;
    logic       r_gate;
    logic       w_gate_d;
    logic [7:0] r_peak;

    logic       w_qual;
    logic [7:0] w_neg;
    logic [7:0] w_mag;
    logic [7:0] w_up;
    logic [7:0] w_dn;
    logic [7:0] w_env_next;

    assign w_qual = i_ce & i_sample_valid;

    // -128 has no positive 8-bit double, so it saturates to full scale.
    assign w_neg = 8'd0 - i_sample;
    always_comb begin
        if (i_sample == 8'h80) begin
            w_mag = 8'hFF;
        end else if (i_sample[7]) begin
            w_mag = {w_neg[6:0], 1'b0};
        end else begin
            w_mag = {i_sample[6:0], 1'b0};
        end
    end

    assign w_up = w_mag - r_env;
    assign w_dn = r_env - w_mag;

    // Step is clamped to the distance to the target, so no wrap is possible.
    always_comb begin
        w_env_next = r_env;
        if (w_mag > r_env) begin
            w_env_next = r_env + ((i_ai < w_up) ? i_ai : w_up);
        end else if (w_mag < r_env) begin
            w_env_next = r_env - ((i_ri < w_dn) ? i_ri : w_dn);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
        end else if (w_qual) begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_env_next >= i_th_on) begin
                    w_state_d = StOn;
                end
            end
            StOn: begin
                if (w_env_next < i_th_off) begin
                    if (i_hold == 8'd0) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StHold;
                        w_cnt_d   = i_hold;
                    end
                end
            end
            StHold: begin
                if (w_env_next >= i_th_on) begin
                    w_state_d = StOn;
                end else if (r_cnt <= 8'd1) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_gate_d = (w_state_d == StOn) || (w_state_d == StHold);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_env  <= 8'd0;
            r_gate <= 1'b0;
        end else if (w_qual) begin
            r_env  <= w_env_next;
            r_gate <= w_gate_d;
        end
    end

    // Clear captures the pre-update envelope and wins over a same-edge update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_peak <= 8'd0;
        end else if (i_ce && i_peak_clr) begin
            r_peak <= r_env;
        end else if (w_qual && (w_env_next > r_peak)) begin
            r_peak <= w_env_next;
        end
    end

    assign o_envelope = r_env;
    assign o_gate     = r_gate;
    assign o_peak     = r_peak;

endmodule

// File: tb/tb_env_follower.sv
// Bench for env_follower: directed scenarios then random traffic against a behavioural model.
module tb_env_follower;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;
    logic [7:0] ai = 8'd0;
    logic [7:0] ri = 8'd0;
    logic [7:0] th_on = 8'd128;
    logic [7:0] th_off = 8'd64;
    logic [7:0] hold = 8'd3;
    logic       peak_clr = 1'b0;
    logic [7:0] envelope;
    logic       gate;
    logic [7:0] peak;

    int checks = 0;
    int errors = 0;

    // Model state: envelope, gate level, whether the hold countdown runs, updates left.
    int  m_env = 0;
    int  m_peak = 0;
    bit  m_gate = 1'b0;
    bit  m_holding = 1'b0;
    int  m_left = 0;

    always #5 clk = ~clk;

    env_follower dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ce           (ce),
        .i_sample_valid (sample_valid),
        .i_sample       (sample),
        .i_ai           (ai),
        .i_ri           (ri),
        .i_th_on        (th_on),
        .i_th_off       (th_off),
        .i_hold         (hold),
        .i_peak_clr     (peak_clr),
        .o_envelope     (envelope),
        .o_gate         (gate),
        .o_peak         (peak)
    );

    task automatic chk(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_env = 0;
        m_peak = 0;
        m_gate = 1'b0;
        m_holding = 1'b0;
        m_left = 0;
    endtask

    task automatic model_edge();
        int s;
        int mag;
        int en;
        if (!ce) return;
        en = m_env;
        if (sample_valid) begin
            s = int'($signed(sample));
            mag = (s == -128) ? 255 : 2 * ((s < 0) ? -s : s);
            if (mag > m_env) en = m_env + ((int'(ai) < mag - m_env) ? int'(ai) : mag - m_env);
            else en = m_env - ((int'(ri) < m_env - mag) ? int'(ri) : m_env - mag);
            if (!m_gate) begin
                if (en >= int'(th_on)) m_gate = 1'b1;
            end else if (!m_holding) begin
                if (en < int'(th_off)) begin
                    if (hold == 8'd0) m_gate = 1'b0;
                    else begin
                        m_holding = 1'b1;
                        m_left = int'(hold);
                    end
                end
            end else begin
                if (en >= int'(th_on)) m_holding = 1'b0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_gate = 1'b0;
                        m_holding = 1'b0;
                    end
                end
            end
        end
        if (peak_clr) m_peak = m_env;
        else if (sample_valid && en > m_peak) m_peak = en;
        m_env = en;
    endtask

    // One clock with the given controls, then compare all outputs with the model.
    task automatic step(input bit c, input bit v, input logic [7:0] s, input bit pc,
                        input string tag);
        ce = c;
        sample_valid = v;
        sample = s;
        peak_clr = pc;
        @(posedge clk);
        #1;
        model_edge();
        chk({tag, ".env"}, int'(envelope), m_env);
        chk({tag, ".gate"}, int'(gate), int'(m_gate));
        chk({tag, ".peak"}, int'(peak), m_peak);
    endtask

    initial begin
        #12;
        chk("reset.env", int'(envelope), 0);
        chk("reset.gate", int'(gate), 0);
        chk("reset.peak", int'(peak), 0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-stream asynchronous reset with envelope 200, gate high.
        ai = 8'd255; ri = 8'd255; th_on = 8'd128; th_off = 8'd64; hold = 8'd3;
        step(1, 1, 8'd100, 0, "pre_rst");
        chk("pre_rst.env_const", int'(envelope), 200);
        chk("pre_rst.gate_const", int'(gate), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.env", int'(envelope), 0);
        chk("async_rst.gate", int'(gate), 0);
        chk("async_rst.peak", int'(peak), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 8'd0, 0, "post_rst");
        chk("post_rst.env_const", int'(envelope), 0);

        // Attack slew with ce=0 gaps; valid during ce=0 is dropped.
        ai = 8'd16; th_on = 8'd255; th_off = 8'd0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, 8'd100, 0, "attack");
            chk("attack.const", int'(envelope), (16 * i < 200) ? 16 * i : 200);
            step(0, 1, 8'd0, 1, "attack_gap");
        end

        // -128 saturates to 255, then release in steps of 50.
        ai = 8'd255; ri = 8'd50;
        step(1, 1, 8'h80, 0, "neg128");
        chk("neg128.const", int'(envelope), 255);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 8'd0, 0, "release");
            chk("release.const", int'(envelope), (205 - 50 * i > 0) ? 205 - 50 * i : 0);
        end

        // Gate hysteresis with hold=3.
        ri = 8'd255; th_on = 8'd128; th_off = 8'd64; hold = 8'd3;
        step(1, 1, 8'd80, 0, "gate_on");
        chk("gate_on.const", int'(gate), 1);
        step(1, 1, 8'd10, 0, "hold_enter");
        chk("hold_enter.const", int'(gate), 1);
        step(1, 1, 8'd10, 0, "hold1");
        chk("hold1.const", int'(gate), 1);
        step(0, 0, 8'd10, 0, "hold_gap");
        step(1, 1, 8'd10, 0, "hold2");
        chk("hold2.const", int'(gate), 1);
        step(1, 1, 8'd10, 0, "hold3");
        chk("hold3.const", int'(gate), 0);

        // Re-trigger during hold keeps the gate up.
        step(1, 1, 8'd80, 0, "retrig_on");
        step(1, 1, 8'd10, 0, "retrig_hold");
        step(1, 1, 8'd80, 0, "retrig");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'd80, 0, "retrig_stay");
            chk("retrig_stay.const", int'(gate), 1);
        end

        // Zero hold: gate drops on the same edge as the envelope crosses th_off.
        hold = 8'd0; ri = 8'd40;
        for (int i = 0; i < 4; i++) step(1, 1, 8'd0, 0, "zero_hold");
        chk("zero_hold.const", int'(gate), 0);

        // Peak: clear at zero, ramp to 200, release to 40, clear with update.
        ri = 8'd255; ai = 8'd255;
        for (int i = 0; i < 3; i++) step(1, 1, 8'd0, 0, "pk_zero");
        step(1, 0, 8'd0, 1, "pk_clr0");
        chk("pk_clr0.const", int'(peak), 0);
        step(1, 1, 8'd100, 0, "pk_ramp");
        step(1, 1, 8'd20, 0, "pk_rel");
        chk("pk_rel.env_const", int'(envelope), 40);
        chk("pk_rel.peak_const", int'(peak), 200);
        ai = 8'd16;
        step(1, 1, 8'd100, 1, "pk_clr");
        chk("pk_clr.peak_const", int'(peak), 40);
        step(1, 1, 8'd100, 0, "pk_track");
        chk("pk_track.peak_const", int'(peak), 72);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                ai = 8'($urandom);
                ri = 8'($urandom);
                th_on = 8'($urandom);
                th_off = 8'($urandom);
                hold = 8'($urandom_range(0, 5));
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 8'($urandom),
                 ($urandom_range(0, 9) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/env_follower.md
# env_follower

Envelope follower and gate detector: the analysis-side counterpart of the `adsr` generator. It rectifies a signed audio sample stream, tracks its amplitude with programmable attack/release slew limits, and derives a hysteretic gate with hold time. The `gate` output can drive the `trig` input of `adsr` directly, and `envelope` uses the same 8-bit unsigned scale as the generator. It sits on the sample-rate `ce` strobe domain, next to the envelope generators.

## Interface
- No parameters; all widths fixed at 8 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  sample-rate clock enable; no state changes when 0.
- `sample_valid`  in  1  `sample` is valid this cycle; ignored when `ce`=0.
- `sample`  in  8  signed two's-complement audio sample.
- `ai`  in  8  attack step: maximum envelope rise per qualified update.
- `ri`  in  8  release step: maximum envelope fall per qualified update.
- `th_on`  in  8  gate-on threshold, unsigned.
- `th_off`  in  8  gate-off threshold, unsigned.
- `hold`  in  8  number of qualified updates the gate stays high after the envelope drops below `th_off`.
- `peak_clr`  in  1  clears `peak`; qualified by `ce`.
- `envelope`  out  8  tracked amplitude, unsigned, registered.
- `gate`  out  1  hysteretic gate, registered.
- `peak`  out  8  maximum `envelope` since the last reset or clear, registered.

## Operation
- A qualified update is a rising edge with `ce`=1 and `sample_valid`=1. Config inputs are sampled live at each qualified update.
- Rectify: `mag` = 2·|`sample`|, 8 bits unsigned.
  - 0→0, 127→254, −1→2, −127→254.
  - −128 maps to 255.
- Envelope, computing `env_next` from `envelope` (E) and `mag` (M):
  - M > E: `env_next` = E + min(`ai`, M−E).
  - M < E: `env_next` = E − min(`ri`, E−M).
  - M = E: `env_next` = E.
  - No wrap-around is possible. The step is clamped to the distance to M, so the envelope never crosses the target.
  - `ai`=0 freezes the rise; `ri`=0 freezes the fall.
- Gate FSM (states IDLE, ON, HOLD). All comparisons use `env_next`, and transitions occur only on qualified updates.
  - IDLE (`gate`=0): `env_next` ≥ `th_on` → ON.
  - ON (`gate`=1): if `env_next` < `th_off`, load `cnt`=`hold` and go to HOLD, or go directly to IDLE if `hold`=0.
  - HOLD (`gate`=1):
    - `env_next` ≥ `th_on` → ON.
    - Otherwise, if `cnt` ≤ 1 → IDLE.
    - Otherwise `cnt` ← `cnt`−1.
  - The gate therefore falls on exactly the `hold`-th qualified update after HOLD entry, unless the envelope re-crosses `th_on`.
  - `th_off` > `th_on` is a misconfiguration. The same rules still apply, and oscillation between ON and HOLD is permitted.
  - Unused state encodings → IDLE on the next qualified update.
- Peak:
  - On any `ce`=1 edge with `peak_clr`=1: `peak` ← `envelope` (current value, not `env_next`).
  - Otherwise, on a qualified update: `peak` ← max(`peak`, `env_next`).
  - `peak_clr` wins over a simultaneous update.

## Timing
- Reset values: `envelope`=0, `gate`=0, `peak`=0, state IDLE, `cnt`=0. Reset takes effect immediately and asynchronously, including mid-attack or mid-HOLD.
- Latency: one clock. `envelope`, `gate` and `peak` reflect a sample on the edge that qualifies it, and hold until the next qualified update.
- `sample_valid`=1 with `ce`=0 is dropped; it is neither buffered nor counted.
- Back-to-back qualified updates on consecutive clocks are supported; there are no throughput limits.
- `gate` and `envelope` change on the same edge.

## Test plan
- Reset check: assert `rst` mid-stream with `envelope`=200 and gate high → outputs read 0/0/0 before the next clock edge. After release, the first qualified sample 0 → `envelope` stays 0.
- Attack slew: `ai`=16, `sample`=100 (M=200) held for 20 qualified updates from 0 → `envelope` reads 16, 32, …, 192, 200, then stays at 200. `ce`=0 cycles in between cause no change.
- Release and −128 handling:
  - From `envelope`=255, `ri`=50, `sample`=0 → `envelope` reads 205, 155, 105, 55, 5, 0.
  - `sample`=−128 with `ai`=255 from 0 → `envelope` reads 255.
- Gate hysteresis and hold: `th_on`=128, `th_off`=64, `hold`=3, `ai`=`ri`=255.
  - `sample`=80 → `envelope`=160 and `gate`=1.
  - `sample`=10 → `envelope`=20, and gate stays 1 for 2 more qualified updates, falling on the 3rd.
  - Repeat with `sample`=80 arriving during HOLD → gate never drops.
- Zero hold: `hold`=0, same thresholds → gate falls on the same edge that `envelope` first drops below 64.
- Peak tracking: ramp to 200, then release to 40 → `peak`=200. Apply `peak_clr` together with a qualified sample → `peak`=40 (pre-update `envelope`), and it tracks upward afterwards.
